object_renderer: RTL



---
 rtl/render_pkg.sv | 28 ++
 rtl/box_hit.sv | 21 ++
 rtl/object_renderer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/render_pkg.sv
// Shared types and constants for the object renderer: coordinate/colour widths,
// default palette, bounding-box record and sequencing states.
package render_pkg;

   localparam int COORD_W = 12;
   localparam int RGB_W   = 3;

   localparam logic [RGB_W-1:0] BG_COLOR_D       = 3'b000;
   localparam logic [RGB_W-1:0] BALL_COLOR_D     = 3'b111;
   localparam logic [RGB_W-1:0] PADDLE_A_COLOR_D = 3'b010;
   localparam logic [RGB_W-1:0] PADDLE_B_COLOR_D = 3'b001;

   typedef struct packed {
      logic [COORD_W-1:0] x1;
      logic [COORD_W-1:0] x2;
      logic [COORD_W-1:0] y1;
      logic [COORD_W-1:0] y2;
   } box_t;

   // x1>x2 and y1>y2: draws nothing until the first frame capture
   localparam box_t EMPTY_BOX = '{x1: 12'd1, x2: 12'd0, y1: 12'd1, y2: 12'd0};

   typedef enum logic {
      WAIT_FRAME = 1'b0,
      RENDER     = 1'b1
   } state_t;

endpackage

// File: rtl/box_hit.sv
// Inclusive unsigned point-in-box test; an inverted box (x1>x2 or y1>y2) is
// empty rather than wrapping around the screen edge.
module box_hit
   import render_pkg::*;
(
   input  box_t               i_box,
   input  logic [COORD_W-1:0] i_x,
   input  logic [COORD_W-1:0] i_y,
   output logic               o_inside
);

   logic w_empty;
   logic w_in_x;
   logic w_in_y;

   assign w_empty  = (i_box.x1 > i_box.x2) || (i_box.y1 > i_box.y2);
   assign w_in_x   = (i_x >= i_box.x1) && (i_x <= i_box.x2);
   assign w_in_y   = (i_y >= i_box.y1) && (i_y <= i_box.y2);
   assign o_inside = !w_empty && w_in_x && w_in_y;

endmodule

// File: rtl/object_renderer.sv
// Frame-latched ball/paddle renderer with 2-strobe hit-test pipeline and
// once-per-frame ball/paddle collision pulses.
//
//   state      | meaning
//   WAIT_FRAME | after reset; shadows empty, no hit pulse on next frame start
//   RENDER     | drawing; frame start recaptures boxes and pulses sticky hits
module object_renderer
   import render_pkg::*;
#(
   parameter logic [RGB_W-1:0] BG_COLOR       = BG_COLOR_D,
   parameter logic [RGB_W-1:0] BALL_COLOR     = BALL_COLOR_D,
   parameter logic [RGB_W-1:0] PADDLE_A_COLOR = PADDLE_A_COLOR_D,
   parameter logic [RGB_W-1:0] PADDLE_B_COLOR = PADDLE_B_COLOR_D
) (
   input  logic               in_clock,
   input  logic               in_reset,
   input  logic               in_pix_stb,
   input  logic               in_frame_start,
   input  logic               in_active,
   input  logic [COORD_W-1:0] in_x,
   input  logic [COORD_W-1:0] in_y,
   input  logic [COORD_W-1:0] in_ball_x1,
   input  logic [COORD_W-1:0] in_ball_x2,
   input  logic [COORD_W-1:0] in_ball_y1,
   input  logic [COORD_W-1:0] in_ball_y2,
   input  logic [COORD_W-1:0] in_pa_x1,
   input  logic [COORD_W-1:0] in_pa_x2,
   input  logic [COORD_W-1:0] in_pa_y1,
   input  logic [COORD_W-1:0] in_pa_y2,
   input  logic [COORD_W-1:0] in_pb_x1,
   input  logic [COORD_W-1:0] in_pb_x2,
   input  logic [COORD_W-1:0] in_pb_y1,
   input  logic [COORD_W-1:0] in_pb_y2,
   output logic [RGB_W-1:0]   out_rgb,
   output logic               out_active,
   output logic               out_hit_a,
   output logic               out_hit_b
);

   state_t r_state;
   state_t w_state_next;
   logic   w_pulse_en;

   box_t r_ball;
   box_t r_pa;
   box_t r_pb;

   logic w_ball_in;
   logic w_pa_in;
   logic w_pb_in;

   logic r_s1_ball;
   logic r_s1_pa;
   logic r_s1_pb;
   logic r_s1_active;

   logic [RGB_W-1:0] w_rgb;
   logic             w_coll_a;
   logic             w_coll_b;
   logic             r_sticky_a;
   logic             r_sticky_b;

   box_hit u_hit_ball (.i_box(r_ball), .i_x(in_x), .i_y(in_y), .o_inside(w_ball_in));
   box_hit u_hit_pa   (.i_box(r_pa),   .i_x(in_x), .i_y(in_y), .o_inside(w_pa_in));
   box_hit u_hit_pb   (.i_box(r_pb),   .i_x(in_x), .i_y(in_y), .o_inside(w_pb_in));

   always_comb begin
      w_state_next = r_state;
      w_pulse_en   = 1'b0;
      case (r_state)
         WAIT_FRAME: if (in_frame_start) w_state_next = RENDER;
         RENDER:     if (in_frame_start) w_pulse_en = 1'b1;
         default:    w_state_next = WAIT_FRAME;
      endcase
   end

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         r_state <= WAIT_FRAME;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         r_ball <= EMPTY_BOX;
         r_pa   <= EMPTY_BOX;
         r_pb   <= EMPTY_BOX;
      end else if (in_frame_start) begin
         r_ball <= '{x1: in_ball_x1, x2: in_ball_x2, y1: in_ball_y1, y2: in_ball_y2};
         r_pa   <= '{x1: in_pa_x1,   x2: in_pa_x2,   y1: in_pa_y1,   y2: in_pa_y2};
         r_pb   <= '{x1: in_pb_x1,   x2: in_pb_x2,   y1: in_pb_y1,   y2: in_pb_y2};
      end
   end

   always_comb begin
      w_rgb = BG_COLOR;
      if (!r_s1_active)   w_rgb = '0;
      else if (r_s1_ball) w_rgb = BALL_COLOR;
      else if (r_s1_pa)   w_rgb = PADDLE_A_COLOR;
      else if (r_s1_pb)   w_rgb = PADDLE_B_COLOR;
   end

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         r_s1_ball   <= 1'b0;
         r_s1_pa     <= 1'b0;
         r_s1_pb     <= 1'b0;
         r_s1_active <= 1'b0;
         out_rgb     <= '0;
         out_active  <= 1'b0;
      end else if (in_pix_stb) begin
         r_s1_ball   <= w_ball_in;
         r_s1_pa     <= w_pa_in;
         r_s1_pb     <= w_pb_in;
         r_s1_active <= in_active;
         out_rgb     <= w_rgb;
         out_active  <= r_s1_active;
      end
   end

   // Collision is taken from stage 1 as it is consumed, so it lines up with the drawn pixel
   assign w_coll_a = in_pix_stb && r_s1_active && r_s1_ball && r_s1_pa;
   assign w_coll_b = in_pix_stb && r_s1_active && r_s1_ball && r_s1_pb;

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         r_sticky_a <= 1'b0;
         r_sticky_b <= 1'b0;
         out_hit_a  <= 1'b0;
         out_hit_b  <= 1'b0;
      end else begin
         out_hit_a <= w_pulse_en && r_sticky_a;
         out_hit_b <= w_pulse_en && r_sticky_b;
         if (in_frame_start) begin
            r_sticky_a <= w_coll_a;
            r_sticky_b <= w_coll_b;
         end else begin
            r_sticky_a <= r_sticky_a || w_coll_a;
            r_sticky_b <= r_sticky_b || w_coll_b;
         end
      end
   end

endmodule
